// File: rtl/full_subtractor.sv
// Registered full subtractor: {borrow,diff} = a - b - c over a ripple-borrow chain of WIDTH cells.
// One-cycle latency with a valid strobe; diff/borrow hold their values when no operation is accepted.
module full_subtractor #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             out_valid
);

   logic [WIDTH:0]   bin_w;
   logic [WIDTH-1:0] d_w;

   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             valid_q, valid_d;

   assign bin_w[0] = c;

   // bin_w[i+1] is the borrow-out of cell i and the borrow-in of cell i+1
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign d_w[i]       = a[i] ^ b[i] ^ bin_w[i];
      assign bin_w[i + 1] = (~a[i] & b[i]) | (~a[i] & bin_w[i]) | (b[i] & bin_w[i]);
   end

   always_comb begin
      diff_d   = diff_q;
      borrow_d = borrow_q;
      valid_d  = in_valid;
      if (in_valid) begin
         diff_d   = d_w;
         borrow_d = bin_w[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q   <= '0;
         borrow_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         valid_q  <= valid_d;
      end
   end

   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor at WIDTH 1, 4 and 8 driven in lock-step from one clock.
// Expected results come from signed integer subtraction reduced modulo 2^(WIDTH+1).
module tb_full_subtractor;

   logic       clk;
   logic       rst_n;
   logic       in_valid;

   logic       a1, b1, c1, d1, bo1, v1;
   logic [3:0] a4, b4, d4;
   logic       c4, bo4, v4;
   logic [7:0] a8, b8, d8;
   logic       c8, bo8, v8;

   logic       e_d1, e_b1, e_b4, e_b8, e_v;
   logic [3:0] e_d4;
   logic [7:0] e_d8;

   int checks   = 0;
   int failures = 0;

   full_subtractor #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a1), .b(b1), .c(c1), .diff(d1), .borrow(bo1), .out_valid(v1));

   full_subtractor #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a4), .b(b4), .c(c4), .diff(d4), .borrow(bo4), .out_valid(v4));

   full_subtractor #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a8), .b(b8), .c(c8), .diff(d8), .borrow(bo8), .out_valid(v8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {borrow,diff} as the low WIDTH+1 bits of the true signed difference
   function automatic logic [8:0] ref_sub(input int av, input int bv, input int cv, input int w);
      int r;
      r = av - bv - cv;
      return 9'(r & ((1 << (w + 1)) - 1));
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".d1"}, 32'(d1), 32'(e_d1));
      chk({tag, ".b1"}, 32'(bo1), 32'(e_b1));
      chk({tag, ".d4"}, 32'(d4), 32'(e_d4));
      chk({tag, ".b4"}, 32'(bo4), 32'(e_b4));
      chk({tag, ".d8"}, 32'(d8), 32'(e_d8));
      chk({tag, ".b8"}, 32'(bo8), 32'(e_b8));
      chk({tag, ".v1"}, 32'(v1), 32'(e_v));
      chk({tag, ".v4"}, 32'(v4), 32'(e_v));
      chk({tag, ".v8"}, 32'(v8), 32'(e_v));
   endtask

   task automatic rand_inputs();
      a1 = 1'($urandom_range(0, 1));  b1 = 1'($urandom_range(0, 1));  c1 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15)); c4 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); c8 = 1'($urandom_range(0, 1));
   endtask

   task automatic zero_expect();
      e_d1 = 1'b0; e_b1 = 1'b0;
      e_d4 = '0;   e_b4 = 1'b0;
      e_d8 = '0;   e_b8 = 1'b0;
      e_v  = 1'b0;
   endtask

   // Called away from the clock edge with inputs already applied; advances one edge and checks.
   task automatic cycle(input string tag);
      logic [8:0] r;
      if (in_valid) begin
         r = ref_sub(int'(a1), int'(b1), int'(c1), 1);
         e_d1 = r[0];   e_b1 = r[1];
         r = ref_sub(int'(a4), int'(b4), int'(c4), 4);
         e_d4 = r[3:0]; e_b4 = r[4];
         r = ref_sub(int'(a8), int'(b8), int'(c8), 8);
         e_d8 = r[7:0]; e_b8 = r[8];
      end
      e_v = in_valid;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [2:0] tv;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      rand_inputs();
      zero_expect();
      #1 rst_n = 1'b0;
      #1 check_all("reset");
      #10 rst_n = 1'b1;

      // 1-bit truth table, inputs stepped 000..111
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_inputs();
         tv = 3'(i);
         a1 = tv[2]; b1 = tv[1]; c1 = tv[0];
         cycle($sformatf("tt%0d", i));
      end

      // WIDTH=4 directed vectors
      rand_inputs(); a4 = 4'h3; b4 = 4'h5; c4 = 1'b0;
      cycle("w4_3m5");
      chk("w4_3m5.lit", {27'd0, bo4, d4}, 32'h1E);
      rand_inputs(); a4 = 4'h9; b4 = 4'h4; c4 = 1'b1;
      cycle("w4_9m4m1");
      chk("w4_9m4m1.lit", {27'd0, bo4, d4}, 32'h04);

      // maximum underflow on all widths
      a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
      a4 = 4'h0; b4 = 4'hF; c4 = 1'b1;
      a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1;
      cycle("underflow");
      chk("underflow.lit", {23'd0, bo8, d8}, 32'h100);

      // a == b, c == 0
      a8 = 8'hA5; b8 = 8'hA5; c8 = 1'b0;
      a4 = 4'h7;  b4 = 4'h7;  c4 = 1'b0;
      a1 = 1'b1;  b1 = 1'b1;  c1 = 1'b0;
      cycle("equal");
      chk("equal.lit", {23'd0, bo8, d8}, 32'h0);

      // hold with changing inputs
      rand_inputs(); a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
      cycle("pre_hold");
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         cycle($sformatf("hold%0d", i));
      end
      chk("hold.lit", {23'd0, bo8, d8}, 32'h1F0);

      // reset mid-stream: in-flight op discarded
      in_valid = 1'b1;
      rand_inputs();
      #2 rst_n = 1'b0;
      zero_expect();
      #1 check_all("rst_async");
      @(posedge clk);
      #1 check_all("rst_held");
      rst_n = 1'b1;
      rand_inputs();
      cycle("post_rst");

      // random back-to-back stream with occasional idle cycles
      for (int i = 0; i < 1000; i++) begin
         in_valid = ($urandom_range(0, 7) != 0);
         rand_inputs();
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
